// File: rtl/knn_pkg.sv
// Shared types and helpers for the k-nearest-neighbour sort controller.
package knn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4
  } knn_state_e;

  // Widest distance supported; modules slice the low W bits for padding.
  localparam int PAD_MAX_W = 64;
  localparam logic [PAD_MAX_W-1:0] PAD_ONES = {PAD_MAX_W{1'b1}};

  function automatic int clog2(input int value);
    int r;
    int pow;
    r   = 32'sd0;
    pow = 32'sd1;
    while (pow < value) begin
      pow = pow * 32'sd2;
      r   = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/knn_frame_buf.sv
// L-entry frame register file: indexed writes, and on the final write of a frame
// every higher entry is padded so the sorter pushes it to the far end.
module knn_frame_buf
  import knn_pkg::*;
#(
  parameter int L      = 64,
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int CNT_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_last,
  input  logic [CNT_W-1:0]    wr_idx,
  input  logic [W-1:0]        wr_dist,
  input  logic [TYPE_W-1:0]   wr_type,
  output logic [W*L-1:0]      frame_dist,
  output logic [TYPE_W*L-1:0] frame_type
);

  // Entry storage with write-and-pad on the closing sample of a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_dist <= {(W*L){1'b0}};
      frame_type <= {(TYPE_W*L){1'b0}};
    end else if (wr_en) begin
      for (int i = 32'sd0; i < L; i++) begin
        if (CNT_W'(i) == wr_idx) begin
          frame_dist[i*W +: W]           <= wr_dist;
          frame_type[i*TYPE_W +: TYPE_W] <= wr_type;
        end else if (wr_last && (CNT_W'(i) > wr_idx)) begin
          frame_dist[i*W +: W]           <= PAD_ONES[W-1:0];
          frame_type[i*TYPE_W +: TYPE_W] <= {TYPE_W{1'b0}};
        end
      end
    end
  end

endmodule

// File: rtl/knn_sort_ctrl.sv
// Collects a frame of distance samples, launches an external sorter, and
// streams the K nearest results out over a valid/ready port.
module knn_sort_ctrl
  import knn_pkg::*;
#(
  parameter int L       = 64,
  parameter int W       = 16,
  parameter int TYPE_W  = 3,
  parameter int K       = 8,
  parameter int TIMEOUT = 1024,
  localparam int IDX_W  = (K > 1) ? clog2(K) : 1,
  localparam int CNT_W  = clog2(L) + 1,
  localparam int TMO_W  = clog2(TIMEOUT) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [W-1:0]        s_dist,
  input  logic [TYPE_W-1:0]   s_type,
  input  logic                s_last,
  output logic                sort_in_valid,
  output logic                sort_ascending,
  output logic [W*L-1:0]      sort_in,
  output logic [TYPE_W*L-1:0] sort_in_type,
  input  logic [W*L-1:0]      sort_out,
  input  logic [TYPE_W*L-1:0] sort_out_type,
  input  logic                sort_out_valid,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [W-1:0]        m_dist,
  output logic [TYPE_W-1:0]   m_type,
  output logic [IDX_W-1:0]    m_idx,
  output logic                m_last,
  output logic                busy,
  output logic                err_timeout
);

  knn_state_e           state_r;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     n_r;
  logic [IDX_W-1:0]     r_r;
  logic [TMO_W-1:0]     tmo_r;
  logic [W*K-1:0]       cap_dist_r;
  logic [TYPE_W*K-1:0]  cap_type_r;

  logic                 accept_s;
  logic [CNT_W-1:0]     wr_idx_s;
  logic                 wr_last_s;
  logic [CNT_W-1:0]     n_sel_s;
  logic [IDX_W-1:0]     r_nxt_s;

  assign sort_ascending = 1'b1;
  // s_ready is only ever high in IDLE/FILL, so it alone qualifies a write.
  assign accept_s  = s_valid && s_ready;
  assign wr_idx_s  = (state_r == ST_IDLE) ? {CNT_W{1'b0}} : count_r;
  assign wr_last_s = s_last || (wr_idx_s == CNT_W'(L - 1));
  assign n_sel_s   = (count_r < CNT_W'(K)) ? count_r : CNT_W'(K);
  assign r_nxt_s   = r_r + IDX_W'(1'b1);

  generate
    if (K < L) begin : g_unused_tail
      logic unused_tail_s;
      assign unused_tail_s = ^{sort_out[W*L-1:W*K], sort_out_type[TYPE_W*L-1:TYPE_W*K]};
    end
  endgenerate

  knn_frame_buf #(
    .L      (L),
    .W      (W),
    .TYPE_W (TYPE_W),
    .CNT_W  (CNT_W)
  ) u_frame_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (accept_s),
    .wr_last    (wr_last_s),
    .wr_idx     (wr_idx_s),
    .wr_dist    (s_dist),
    .wr_type    (s_type),
    .frame_dist (sort_in),
    .frame_type (sort_in_type)
  );

  // Controller FSM; every output is registered and set on the transition into its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      count_r       <= {CNT_W{1'b0}};
      n_r           <= {CNT_W{1'b0}};
      r_r           <= {IDX_W{1'b0}};
      tmo_r         <= {TMO_W{1'b0}};
      cap_dist_r    <= {(W*K){1'b0}};
      cap_type_r    <= {(TYPE_W*K){1'b0}};
      s_ready       <= 1'b0;
      sort_in_valid <= 1'b0;
      m_valid       <= 1'b0;
      m_dist        <= {W{1'b0}};
      m_type        <= {TYPE_W{1'b0}};
      m_idx         <= {IDX_W{1'b0}};
      m_last        <= 1'b0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      sort_in_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (accept_s) begin
            count_r <= CNT_W'(1);
            busy    <= 1'b1;
            if (wr_last_s) begin
              state_r       <= ST_LAUNCH;
              s_ready       <= 1'b0;
              sort_in_valid <= 1'b1;
            end else begin
              state_r <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (accept_s) begin
            count_r <= count_r + CNT_W'(1);
            if (wr_last_s) begin
              state_r       <= ST_LAUNCH;
              s_ready       <= 1'b0;
              sort_in_valid <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          state_r <= ST_WAIT;
          tmo_r   <= {TMO_W{1'b0}};
        end
        ST_WAIT: begin
          if (sort_out_valid) begin
            cap_dist_r <= sort_out[W*K-1:0];
            cap_type_r <= sort_out_type[TYPE_W*K-1:0];
            n_r        <= n_sel_s;
            r_r        <= {IDX_W{1'b0}};
            m_valid    <= 1'b1;
            m_dist     <= sort_out[W-1:0];
            m_type     <= sort_out_type[TYPE_W-1:0];
            m_idx      <= {IDX_W{1'b0}};
            m_last     <= (n_sel_s == CNT_W'(1));
            state_r    <= ST_DRAIN;
          end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
            // Frame is dropped; the buffer is rewritten by the next frame.
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            s_ready     <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        ST_DRAIN: begin
          if (m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              s_ready <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              r_r    <= r_nxt_s;
              m_dist <= cap_dist_r[int'(r_nxt_s)*W +: W];
              m_type <= cap_type_r[int'(r_nxt_s)*TYPE_W +: TYPE_W];
              m_idx  <= r_nxt_s;
              m_last <= (CNT_W'(r_nxt_s) == (n_r - CNT_W'(1)));
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
